// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant bundle between the requesting stages and the round-robin arbiter.
interface mux8_rr_arbiter_if;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;

    // Requesters drive req and observe the grant.
    modport master (
        output req,
        input  gnt,
        input  sel,
        input  valid
    );

    // The arbiter consumes req and produces the grant.
    modport slave (
        input  req,
        output gnt,
        output sel,
        output valid
    );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select lines of a shared 8:1 mux.
// An owner keeps the grant for at most MAX_HOLD cycles while others wait.
module mux8_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    mux8_rr_arbiter_if.slave   bus
);
    localparam int unsigned N  = 8;
    localparam int unsigned IW = 3;
    localparam int unsigned HW = 8;

    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);
    localparam logic [HW-1:0] HOLD_SAT = '1;

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]   sel_q, sel_d;
    logic            valid_q, valid_d;

    logic [IW-1:0]   next_ptr;
    logic [IW-1:0]   win;
    logic            others;

    // First requester found searching start, start+1, ... modulo 8.
    function automatic logic [IW-1:0] pick(input logic [N-1:0] r, input logic [IW-1:0] start);
        logic [IW-1:0] idx;
        logic [IW-1:0] w;
        logic          found;
        w     = start;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = start + IW'(i);
            if (!found && r[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    // Binary index to one-hot grant vector.
    function automatic logic [N-1:0] onehot(input logic [IW-1:0] w);
        logic [N-1:0] v;
        v    = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    // Next-state: grant from idle, continue, preempt on hold limit, or release.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        valid_d  = valid_q;
        win      = '0;
        next_ptr = sel_q + IW'(1);
        others   = |(bus.req & ~onehot(sel_q));

        unique case (state_q)
            IDLE: begin
                gnt_d   = '0;
                valid_d = 1'b0;
                if (|bus.req) begin
                    win     = pick(bus.req, ptr_q);
                    gnt_d   = onehot(win);
                    sel_d   = win;
                    valid_d = 1'b1;
                    hold_d  = '0;
                    state_d = OWN;
                end
            end
            OWN: begin
                if (bus.req[sel_q] && (!others || (hold_q < HOLD_LIM))) begin
                    if (hold_q != HOLD_SAT) begin
                        hold_d = hold_q + HW'(1);
                    end
                end else begin
                    // Preempt or release: rotate priority past the current owner.
                    ptr_d = next_ptr;
                    if (|bus.req) begin
                        win     = pick(bus.req, next_ptr);
                        gnt_d   = onehot(win);
                        sel_d   = win;
                        valid_d = 1'b1;
                        hold_d  = '0;
                    end else begin
                        gnt_d   = '0;
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.gnt   = gnt_q;
    assign bus.sel   = sel_q;
    assign bus.valid = valid_q;
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter: MAX_HOLD=4 and MAX_HOLD=1 instances.
module tb_mux8_rr_arbiter;
    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       valid;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic [7:0] req;
        exp_t       e;
    } row_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] in_vec;
    logic       mux_out;

    int tests_run    = 0;
    int tests_failed = 0;

    exp_t sb[$];
    logic mux_q[$];

    mux8_rr_arbiter_if b4();
    mux8_rr_arbiter_if b1();

    assign b4.req = req;
    assign b1.req = req;

    mux8_rr_arbiter #(.MAX_HOLD(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    mux8_rr_arbiter #(.MAX_HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    // Shared 8:1 bit-select datapath steered by the MAX_HOLD=1 arbiter.
    assign mux_out = in_vec[b1.sel];

    always #5 clk = ~clk;

    task automatic do_reset();
        req = 8'h00;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        row_t rows[9];
        exp_t e;
        exp_t g;
        rows = '{
            {1'b0, 8'hFF, 8'h00, 3'd0, 1'b0},
            {1'b0, 8'hFF, 8'h00, 3'd0, 1'b0},
            {1'b1, 8'hFF, 8'h01, 3'd0, 1'b1},
            {1'b1, 8'hFF, 8'h01, 3'd0, 1'b1},
            {1'b1, 8'hFF, 8'h01, 3'd0, 1'b1},
            {1'b1, 8'hFF, 8'h01, 3'd0, 1'b1},
            {1'b1, 8'hFF, 8'h02, 3'd1, 1'b1},
            {1'b0, 8'hFF, 8'h00, 3'd0, 1'b0},
            {1'b1, 8'hFF, 8'h01, 3'd0, 1'b1}
        };
        for (int i = 0; i < 9; i++) begin
            rst = rows[i].rst;
            req = rows[i].req;
            sb.push_back(rows[i].e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            g = {b4.gnt, b4.sel, b4.valid};
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL reset[%0d]: got gnt=%h sel=%0d valid=%b, expected gnt=%h sel=%0d valid=%b",
                         i, g.gnt, g.sel, g.valid, e.gnt, e.sel, e.valid);
            end
        end
    endtask

    task automatic test_rotation();
        exp_t e;
        exp_t g;
        int   owner;
        do_reset();
        req = 8'hFF;
        for (int c = 0; c < 36; c++) begin
            owner   = (c / 4) % 8;
            e.gnt   = 8'h01 << owner;
            e.sel   = 3'(owner);
            e.valid = 1'b1;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            g = {b4.gnt, b4.sel, b4.valid};
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL rotation[%0d]: got gnt=%h sel=%0d valid=%b, expected gnt=%h sel=%0d valid=%b",
                         c, g.gnt, g.sel, g.valid, e.gnt, e.sel, e.valid);
            end
        end
    endtask

    task automatic test_release_handoff();
        row_t rows[4];
        exp_t e;
        exp_t g;
        rows = '{
            {1'b1, 8'h04, 8'h04, 3'd2, 1'b1},
            {1'b1, 8'h84, 8'h04, 3'd2, 1'b1},
            {1'b1, 8'h80, 8'h80, 3'd7, 1'b1},
            {1'b1, 8'h80, 8'h80, 3'd7, 1'b1}
        };
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req = rows[i].req;
            sb.push_back(rows[i].e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            g = {b4.gnt, b4.sel, b4.valid};
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL handoff[%0d]: got gnt=%h sel=%0d valid=%b, expected gnt=%h sel=%0d valid=%b",
                         i, g.gnt, g.sel, g.valid, e.gnt, e.sel, e.valid);
            end
        end
    endtask

    task automatic test_lone_idle();
        exp_t e;
        exp_t g;
        do_reset();
        for (int c = 0; c < 303; c++) begin
            if (c < 300) begin
                req = 8'h20;
                e   = {8'h20, 3'd5, 1'b1};
            end else begin
                req = 8'h00;
                e   = {8'h00, 3'd5, 1'b0};
            end
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            g = {b4.gnt, b4.sel, b4.valid};
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL lone_idle[%0d]: got gnt=%h sel=%0d valid=%b, expected gnt=%h sel=%0d valid=%b",
                         c, g.gnt, g.sel, g.valid, e.gnt, e.sel, e.valid);
            end
        end
    endtask

    task automatic test_pointer_fairness();
        row_t rows[7];
        exp_t e;
        exp_t g;
        rows = '{
            {1'b1, 8'h40, 8'h40, 3'd6, 1'b1},
            {1'b1, 8'h00, 8'h00, 3'd6, 1'b0},
            {1'b1, 8'h41, 8'h01, 3'd0, 1'b1},
            {1'b1, 8'h00, 8'h00, 3'd0, 1'b0},
            {1'b1, 8'h41, 8'h40, 3'd6, 1'b1},
            {1'b1, 8'h00, 8'h00, 3'd6, 1'b0},
            {1'b1, 8'hC0, 8'h80, 3'd7, 1'b1}
        };
        do_reset();
        for (int i = 0; i < 7; i++) begin
            req = rows[i].req;
            sb.push_back(rows[i].e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            g = {b4.gnt, b4.sel, b4.valid};
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL fairness[%0d]: got gnt=%h sel=%0d valid=%b, expected gnt=%h sel=%0d valid=%b",
                         i, g.gnt, g.sel, g.valid, e.gnt, e.sel, e.valid);
            end
        end
    endtask

    task automatic test_datapath();
        logic [7:0] pattern;
        exp_t e;
        exp_t g;
        logic m;
        int   owner;
        pattern = 8'b0011_0011;
        in_vec  = pattern;
        do_reset();
        req = 8'h0F;
        for (int c = 0; c < 12; c++) begin
            owner   = c % 4;
            e.gnt   = 8'h01 << owner;
            e.sel   = 3'(owner);
            e.valid = 1'b1;
            sb.push_back(e);
            mux_q.push_back(pattern[owner]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            m = mux_q.pop_front();
            g = {b1.gnt, b1.sel, b1.valid};
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL datapath_gnt[%0d]: got gnt=%h sel=%0d valid=%b, expected gnt=%h sel=%0d valid=%b",
                         c, g.gnt, g.sel, g.valid, e.gnt, e.sel, e.valid);
            end
            tests_run++;
            if (mux_out !== m) begin
                tests_failed++;
                $display("FAIL datapath_mux[%0d]: got %b, expected %b", c, mux_out, m);
            end
        end
    endtask

    initial begin
        rst    = 1'b0;
        req    = 8'h00;
        in_vec = 8'h00;
        test_reset();
        test_rotation();
        test_release_handoff();
        test_lone_idle();
        test_pointer_fairness();
        test_datapath();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter that shares one 8:1 bit-select datapath (a `mux_8` instance) among eight requesters. It accepts a request vector, chooses one owner per grant period, and drives the owner's index straight onto the mux select lines. An owner keeps the mux for a bounded number of cycles, so no requester can starve the others. The block sits between the requesting stages and the shared `mux_8`. Its `sel` output wires directly to the mux `SEL` input.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive cycles one owner may hold the grant while any other requester is waiting. Legal range is 1..255.
- `clk`  in  1  single clock for the block; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-low. Sampled only on the `clk` rising edge; `rst`=0 resets all state.
- `req`  in  8  request vector; bit i=1 means requester i wants the mux. Level-sensitive.
- `gnt`  out  8  one-hot grant; bit i=1 means requester i owns the mux this cycle. All zero when idle.
- `sel`  out  3  binary index of the current owner, connected to mux `SEL`. Holds its last value when idle.
- `valid`  out  1  1 when `gnt` is non-zero. This equals the OR-reduction of `gnt`.

## Operation
- **Registers:**
  - `gnt`, `sel` and `valid` are registered outputs.
  - `ptr[2:0]` is the round-robin start point.
  - `hold[7:0]` counts cycles held by the current owner.
  - `state` is one of IDLE or OWN.
- **Reset:** `gnt`=8'h00, `sel`=3'd0, `valid`=0, `ptr`=3'd0, `hold`=0, `state`=IDLE.
- **Pick function:** the winner is the first i with `req[i]`=1, searching ptr, ptr+1, …, ptr+7 modulo 8.
- **IDLE:**
  - If `req`==0, stay in IDLE; outputs unchanged except `gnt`=0 and `valid`=0.
  - Otherwise, grant the pick winner w: `gnt`=1<<w, `sel`=w, `valid`=1, `hold`=0, go to OWN.
- **OWN, current owner o:**
  - **Continue:** `req[o]`=1 and (no other request, or `hold` < MAX_HOLD-1).
    - Keep the grant and increment `hold`.
    - `hold` saturates at 255.
  - **Preempt:** `req[o]`=1, another request is present, and `hold` ≥ MAX_HOLD-1.
    - Set `ptr`=o+1 (mod 8).
    - Regrant to the pick winner using the new ptr; since another request is present, the winner is never o.
  - **Release:** `req[o]`=0.
    - Set `ptr`=o+1 (mod 8).
    - If another request is present, regrant to the pick winner on the same edge with no idle bubble, and set `hold`=0.
    - Otherwise set `gnt`=0, `valid`=0 and go to IDLE. `sel` keeps o.
- **Pointer wrap:** `ptr` advances 7→0 by 3-bit wrap; no special case is needed.
- **Single requester:** a lone requester holds the grant indefinitely; `hold` saturates and has no effect.
- **Invariant:** `gnt` is always one-hot or zero. Whenever `valid`=1, `gnt`[`sel`]=1.
- **Reset mid-grant:** `rst`=0 on any edge forces the reset values on that edge, regardless of `req`. The first grant after reset restarts priority at requester 0.

## Timing
- Grant latency is one cycle: `req` sampled at edge k produces `gnt`/`sel` valid after edge k.
- With MAX_HOLD=M and contention, an owner holds the grant for exactly M cycles. Switch-over takes zero idle cycles.
- After a release with no other requester, `valid` drops one cycle after `req[o]` falls.
- The mux output is combinational from `sel`, so mux data reflects the new owner in the same cycle `sel` changes.
- Worst-case wait for a requester under full contention is 7·M cycles.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles with `req`=8'hFF -> `gnt`=00, `sel`=0, `valid`=0. Release reset -> next cycle `gnt`=01, `sel`=0.
- **Full contention rotation:** MAX_HOLD=4, `req`=8'hFF held -> grants 0,1,…,7,0 with each owner held exactly 4 cycles. `sel` steps 0→7 then wraps to 0; `valid` stays 1 throughout.
- **Release handoff:** owner 2 held, `req`=8'h84. Drop bit 2 -> next cycle `gnt`=80, `sel`=7, with no cycle of `valid`=0.
- **Lone requester and idle:** `req`=8'h20 held 300 cycles -> `gnt`=20 the whole time, no preemption. Then `req`=0 -> `valid`=0 next cycle and `sel` remains 5.
- **Pointer fairness:** after owner 6 releases, `req`=8'h41 -> grant goes to 0 (ptr=7 wraps to 0), not 6.
- **Datapath check with mux_8:** mux IN=8'b00110011, `req`=8'h0F, MAX_HOLD=1 -> mux output follows IN[sel] = 1,1,0,0 repeating, one value per cycle.
